// File: rtl/sumatoria_packer.sv
// Packs NW-bit samples MSB-first into a NIBBLES*NW word and keeps a running reference sum,
// then presents word and sum to the Sumatoria stage under a valid/ready handshake.
module sumatoria_packer #(
   parameter int NIBBLES = 4,
   parameter int NW      = 4,
   parameter int SUM_W   = 6,
   localparam int CW     = $clog2(NIBBLES) + 1,
   localparam int OW     = NIBBLES * NW
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Clear,
   input  logic             In_valid,
   input  logic [NW-1:0]    In_data,
   output logic             In_ready,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [OW-1:0]    Output,
   output logic [SUM_W-1:0] Sum,
   output logic [CW-1:0]    Count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // In_ready/Out_valid depend only on the state register, never on the same-cycle inputs.
   typedef enum logic {FILL, HOLD} state_t;

   state_t state, state_next;
   logic   accept;
   logic   drain;

   assign In_ready  = (state == FILL);
   assign Out_valid = (state == HOLD);
   assign accept    = !Clear && (state == FILL) && In_valid;
   assign drain     = !Clear && (state == HOLD) && Out_ready;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= FILL;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (Clear) begin
         state_next = FILL;
      end else begin
         case (state)
            FILL:    if (In_valid && (Count == CW'(NIBBLES - 1))) state_next = HOLD;
            HOLD:    if (Out_ready) state_next = FILL;
            default: state_next = FILL;
         endcase
      end
   end

   // Clear and a completed transfer both restart the word from zero.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Output <= '0;
         Sum    <= '0;
         Count  <= '0;
      end else if (Clear || drain) begin
         Output <= '0;
         Sum    <= '0;
         Count  <= '0;
      end else if (accept) begin
         Output <= (Output << NW) | OW'(In_data);
         Sum    <= Sum + SUM_W'(In_data);
         Count  <= Count + CW'(1);
      end
   end

endmodule

// File: tb/tb_sumatoria_packer.sv
// Directed bench for sumatoria_packer: reset, packing, back-to-back words, backpressure,
// clear, asynchronous reset and a randomised Sumatoria cross-check.
module tb_sumatoria_packer;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Clear;
   logic        In_valid;
   logic [3:0]  In_data;
   logic        In_ready;
   logic        Out_valid;
   logic        Out_ready;
   logic [15:0] Output;
   logic [5:0]  Sum;
   logic [2:0]  Count;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q[$];

   sumatoria_packer #(.NIBBLES(4), .NW(4), .SUM_W(6)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear),
      .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready),
      .Out_valid(Out_valid), .Out_ready(Out_ready),
      .Output(Output), .Sum(Sum), .Count(Count)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [5:0] sumatoria(input logic [15:0] w);
      return {2'b00, w[15:12]} + {2'b00, w[11:8]} + {2'b00, w[7:4]} + {2'b00, w[3:0]};
   endfunction

   task automatic test_reset();
      Reset_n = 1'b0; Clear = 1'b0; In_valid = 1'b0; In_data = '0; Out_ready = 1'b0;
      #3;
      checks++; if (In_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", In_ready); end
      checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", Out_valid); end
      checks++; if (Output !== 16'h0) begin failures++; $display("FAIL reset_output got=%h exp=0000", Output); end
      checks++; if (Sum !== 6'd0) begin failures++; $display("FAIL reset_sum got=%0d exp=0", Sum); end
      checks++; if (Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_basic_pack();
      logic [15:0] w;
      w = 16'h5326;
      Out_ready = 1'b0;
      In_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         In_data = w[15-4*i -: 4];
         tick();
         if (i == 2) begin
            checks++; if (Out_valid !== 1'b0 || Count !== 3'd3) begin failures++; $display("FAIL basic_partial out_valid=%0b count=%0d exp 0/3", Out_valid, Count); end
         end
      end
      In_valid = 1'b0;
      checks++; if (Out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0b exp=1", Out_valid); end
      checks++; if (Output !== 16'h5326) begin failures++; $display("FAIL basic_output got=%h exp=5326", Output); end
      checks++; if (Sum !== 6'd16) begin failures++; $display("FAIL basic_sum got=%0d exp=16", Sum); end
      checks++; if (Count !== 3'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", Count); end
      checks++; if (In_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready got=%0b exp=0", In_ready); end
      Out_ready = 1'b1;
      tick();
      Out_ready = 1'b0;
      checks++; if (Out_valid !== 1'b0 || Output !== 16'h0 || Sum !== 6'd0 || Count !== 3'd0)
         begin failures++; $display("FAIL basic_drain valid=%0b out=%h sum=%0d count=%0d exp 0/0000/0/0", Out_valid, Output, Sum, Count); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words[2];
      logic [5:0]  sums[2];
      words[0] = 16'h2146; sums[0] = 6'd13;
      words[1] = 16'h5176; sums[1] = 6'd19;
      Out_ready = 1'b1;
      In_valid  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) begin
            In_data = words[k][15-4*i -: 4];
            tick();
            if (i < 3) begin
               checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL b2b_early_valid word=%0d i=%0d got=%0b exp=0", k, i, Out_valid); end
            end
         end
         checks++; if (Out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid word=%0d got=%0b exp=1", k, Out_valid); end
         checks++; if (Output !== words[k]) begin failures++; $display("FAIL b2b_output word=%0d got=%h exp=%h", k, Output, words[k]); end
         checks++; if (Sum !== sums[k]) begin failures++; $display("FAIL b2b_sum word=%0d got=%0d exp=%0d", k, Sum, sums[k]); end
         In_data = 4'hA;
         tick();
         checks++; if (Out_valid !== 1'b0 || Count !== 3'd0) begin failures++; $display("FAIL b2b_hold_cycle word=%0d valid=%0b count=%0d exp 0/0", k, Out_valid, Count); end
      end
      In_valid  = 1'b0;
      Out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      Out_ready = 1'b0;
      In_data   = 4'hF;
      for (int i = 0; i < 4; i++) begin
         In_valid = 1'b1;
         tick();
         if (i < 3) begin
            In_valid = 1'b0;
            tick();
            checks++; if (Count !== 3'(i + 1)) begin failures++; $display("FAIL bp_gap_count i=%0d got=%0d exp=%0d", i, Count, i + 1); end
         end
      end
      In_valid = 1'b1;
      In_data  = 4'h9;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (Output !== 16'hFFFF || Sum !== 6'd60 || In_ready !== 1'b0 || Out_valid !== 1'b1 || Count !== 3'd4) begin
            failures++;
            $display("FAIL bp_hold c=%0d out=%h sum=%0d in_ready=%0b valid=%0b count=%0d exp FFFF/60/0/1/4", c, Output, Sum, In_ready, Out_valid, Count);
         end
         tick();
      end
      Out_ready = 1'b1;
      tick();
      Out_ready = 1'b0;
      checks++; if (Count !== 3'd0 || Out_valid !== 1'b0) begin failures++; $display("FAIL bp_release count=%0d valid=%0b exp 0/0", Count, Out_valid); end
      tick();
      In_valid = 1'b0;
      checks++; if (Output !== 16'h0009 || Sum !== 6'd9 || Count !== 3'd1) begin failures++; $display("FAIL bp_restart out=%h sum=%0d count=%0d exp 0009/9/1", Output, Sum, Count); end
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
   endtask

   task automatic test_clear();
      Out_ready = 1'b0;
      In_valid  = 1'b1;
      In_data = 4'd5; tick();
      In_data = 4'd3; tick();
      Clear = 1'b1; In_data = 4'd2;
      tick();
      Clear = 1'b0; In_valid = 1'b0;
      checks++; if (Output !== 16'h0 || Sum !== 6'd0 || Count !== 3'd0 || In_ready !== 1'b1 || Out_valid !== 1'b0)
         begin failures++; $display("FAIL clear_fill out=%h sum=%0d count=%0d in_ready=%0b exp 0000/0/0/1", Output, Sum, Count, In_ready); end
      In_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         In_data = 4'(i + 1);
         tick();
      end
      In_valid = 1'b0;
      checks++; if (Out_valid !== 1'b1 || Output !== 16'h1234 || Sum !== 6'd10) begin failures++; $display("FAIL clear_prefill valid=%0b out=%h sum=%0d exp 1/1234/10", Out_valid, Output, Sum); end
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      checks++; if (Out_valid !== 1'b0 || In_ready !== 1'b1 || Output !== 16'h0 || Sum !== 6'd0 || Count !== 3'd0)
         begin failures++; $display("FAIL clear_hold valid=%0b out=%h sum=%0d count=%0d exp 0/0000/0/0", Out_valid, Output, Sum, Count); end
   endtask

   task automatic test_async_reset();
      Out_ready = 1'b0;
      In_valid  = 1'b1;
      In_data = 4'd7; tick();
      In_data = 4'd8; tick();
      In_data = 4'd9; tick();
      In_valid = 1'b0;
      checks++; if (Count !== 3'd3) begin failures++; $display("FAIL arst_pre_count got=%0d exp=3", Count); end
      #2;
      Reset_n = 1'b0;
      #1;
      checks++; if (Output !== 16'h0 || Sum !== 6'd0 || Count !== 3'd0 || In_ready !== 1'b1 || Out_valid !== 1'b0)
         begin failures++; $display("FAIL arst_immediate out=%h sum=%0d count=%0d in_ready=%0b valid=%0b exp 0000/0/0/1/0", Output, Sum, Count, In_ready, Out_valid); end
      @(negedge Clk);
      Reset_n = 1'b1;
      In_valid = 1'b1;
      In_data = 4'd2; tick();
      In_data = 4'd1; tick();
      In_data = 4'd4; tick();
      In_data = 4'd6; tick();
      In_valid = 1'b0;
      checks++; if (Out_valid !== 1'b1 || Output !== 16'h2146 || Sum !== 6'd13) begin failures++; $display("FAIL arst_after valid=%0b out=%h sum=%0d exp 1/2146/13", Out_valid, Output, Sum); end
      Out_ready = 1'b1;
      tick();
      Out_ready = 1'b0;
   endtask

   task automatic test_system();
      logic [15:0] exp_w;
      logic [5:0]  exp_s;
      int          acc;
      int          holds;
      Out_ready = 1'b0;
      for (int n = 0; n < 200; n++) begin
         exp_w = '0; exp_s = '0; acc = 0;
         for (int c = 0; c < 64 && acc < 4; c++) begin
            In_valid = 1'($urandom_range(0, 1));
            In_data  = 4'($urandom_range(0, 15));
            tick();
            if (In_valid) begin
               exp_w = {exp_w[11:0], In_data};
               exp_s = exp_s + {2'b00, In_data};
               acc++;
            end
         end
         In_valid = 1'b0;
         checks++;
         if (acc < 4) begin
            failures++;
            $display("FAIL sys_timeout word=%0d accepted=%0d exp=4", n, acc);
            Clear = 1'b1; tick(); Clear = 1'b0;
            continue;
         end
         exp_q.push_back(exp_w);
         if (Out_valid !== 1'b1) begin failures++; $display("FAIL sys_valid word=%0d got=%0b exp=1", n, Out_valid); end
         holds = $urandom_range(0, 2);
         for (int h = 0; h <= holds; h++) begin
            Out_ready = (h == holds);
            checks++;
            if (sumatoria(Output) !== Sum || Output !== exp_q[0] || Sum !== exp_s) begin
               failures++;
               $display("FAIL sys_hold word=%0d out=%h sum=%0d sumatoria=%0d exp %h/%0d", n, Output, Sum, sumatoria(Output), exp_q[0], exp_s);
            end
            tick();
         end
         void'(exp_q.pop_front());
         Out_ready = 1'b0;
         checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL sys_drain word=%0d valid=%0b exp=0", n, Out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_back_to_back();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_system();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
